busy_sequencer: RTL and testbench
=================================

# busy_sequencer

Round-robin controller that shares one busy-type resource between `NUM_REQ` requesters. On each grant it issues a one-cycle `start` pulse and then holds `busy` high for exactly the requested number of consecutive cycles. It pulses `done` on the last busy cycle. It is the sequencer that drives the `start`/`busy` pair checked by the consecutive-repetition properties, and it carries its own embedded SVA checks of that contract.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `MAX_LEN`, default 16: maximum burst length in cycles.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of the length field.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the owner index.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-requester level request; held until granted.
- `len`  in  LEN_W  burst length of the winning requester, sampled in the arbitration cycle.
- `gnt`  out  NUM_REQ  one-hot grant, high only in the `start` cycle.
- `start`  out  1  one-cycle job start pulse.
- `busy`  out  1  resource busy, high for L consecutive cycles per job.
- `done`  out  1  one-cycle pulse coincident with the last busy cycle.
- `owner`  out  ID_W  index of the current/last granted requester.

## Operation
- FSM states: IDLE, START, RUN.
- **IDLE**: `busy`=0.
  - If `req`≠0, the arbiter picks a winner, and `len` is captured. Length is L = max(len,1), saturated to MAX_LEN.
  - Next state is START. Otherwise stay in IDLE.
- **START** (exactly 1 cycle):
  - `start`=1, `gnt`=onehot(winner), `owner`=winner, `busy`=0.
  - Counter loads L. Next state is RUN.
- **RUN**:
  - `busy`=1 and the counter decrements each cycle.
  - When counter==1: `done`=1 in that cycle and next state is IDLE.
- Arbitration is round-robin. The priority pointer moves to winner+1 (mod NUM_REQ) on every grant. Reset value of the pointer is 0, so requester 0 has highest priority first.
- Requests arriving during START/RUN are ignored until IDLE. There is no queueing beyond the level `req` inputs.
- A requester that drops `req` before being granted loses its turn, with no side effects.
- The guaranteed contract is `start |=> busy[*L] ##1 !busy`. Because of the IDLE cycle, at least one non-busy cycle always separates consecutive jobs.
- Embedded assertions, clocked by `clk` and disabled by `rst`:
  - `start |=> busy[*L] ##1 !busy`, where L is the captured length.
  - `done |-> busy`.
  - `$onehot0(gnt)`.
  - `start == (gnt != 0)`.
  - `gnt[i] |-> $past(req[i])`.
  - `!(start && busy)`.

## Timing
- Reset values: `gnt`=0, `start`=0, `busy`=0, `done`=0, `owner`=0, FSM=IDLE, pointer=0, counter=0.
- `rst` mid-job: the next cycle all outputs are 0, state is IDLE, and the pointer is 0. No `done` is issued for the aborted job.
- Latency from `req` rising (while in IDLE) to `start` is 1 cycle. From `start` to the first `busy` is 1 cycle.
- A job occupies L+2 cycles: arbitration (IDLE), START, then L RUN cycles. Back-to-back throughput is one job per L+2 cycles.
- `len`=0 is treated as 1. `len`>MAX_LEN is saturated to MAX_LEN.
- All outputs are registered; there are no combinational paths from `req`/`len` to any output.

## Structure
- Package `busy_seq_pkg`: FSM state enum (IDLE, START, RUN) and the length-saturation function.
- Sub-module `rr_arbiter #(NUM_REQ)`:
  - Inputs: `req`, pointer, and `advance`.
  - Outputs: one-hot winner and winner index.
  - Owns the pointer register, which has the same synchronous `rst`.
- Top level contains the FSM, counter, output registers and the embedded assertion block.

## Test plan
- Reset, then `req`=4'b0001, `len`=5 → `start`+`gnt`=0001 one cycle later, `busy` high exactly 5 cycles, `done` in the 5th, then `busy`=0.
- `req`=4'b1111 held, `len`=2 → grants in the order 0,1,2,3,0, each job 4 cycles long, `owner` tracking each grant.
- `len`=0, and separately `len`=20 with MAX_LEN=16 → `busy` lasts 1 cycle and 16 cycles respectively.
- Assert `rst` on the 3rd busy cycle of a `len`=8 job → next cycle all outputs 0, no `done`; a new `req`=0010 after reset is granted to requester 1 (pointer was reset).
- Requester 2 drops `req` one cycle before its turn while 0 and 3 remain requesting → requester 3 is granted next, and `gnt[2]` is never asserted.
- Random `req`/`len` for 10k cycles → zero assertion failures, and every `start` is matched by exactly one `done`.

Source files
------------

// File: rtl/busy_sequencer_pkg.sv
// Shared types and helpers for the busy-resource sequencer.
package busy_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Zero-length requests still occupy the resource for one cycle.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/busy_sequencer_rr_arbiter.sv
// Round-robin arbiter; the priority pointer moves past each winner on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [ID_W-1:0]    win_idx_o
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                win_oh_o[cand] = 1'b1;
                win_idx_o      = cand;
            end
        end
    end

    assign ptr_d = (win_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : win_idx_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            ptr_q <= '0;
        else if (advance_i && found)
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/busy_sequencer.sv
// Shares one busy-type resource between requesters: start pulse, L busy cycles, done on the last.
module busy_sequencer
    import busy_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               start_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [ID_W-1:0]    owner_o
);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               start_q;
    logic               busy_q;
    logic               done_q;
    logic [ID_W-1:0]    owner_q;
    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_idx;
    logic               advance;

    assign advance = (state_q == ST_IDLE) && (req_i != '0);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (advance),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            start_q <= 1'b0;
            gnt_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (advance) begin
                        start_q <= 1'b1;
                        gnt_q   <= win_oh;
                        owner_q <= win_idx;
                        len_q   <= LEN_W'(sat_len(32'(len_i), MAX_LEN));
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= len_q;
                    busy_q  <= 1'b1;
                    done_q  <= (len_q == LEN_W'(1));
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // done_q is registered one cycle ahead so it lands on the last busy cycle
                    if (cnt_q == LEN_W'(1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= (cnt_q == LEN_W'(2));
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign owner_o = owner_q;

`ifndef SYNTHESIS
    // Shadow counter for start |=> busy[*L] ##1 !busy with a run-time L
    logic [LEN_W-1:0] chk_rem;
    logic             chk_tail;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chk_rem  <= '0;
            chk_tail <= 1'b0;
        end else begin
            if (chk_rem != '0) begin
                assert (busy_q);
                chk_rem <= chk_rem - 1'b1;
                if (chk_rem == LEN_W'(1))
                    chk_tail <= 1'b1;
            end else if (chk_tail) begin
                assert (!busy_q);
                chk_tail <= 1'b0;
            end
            if (start_q)
                chk_rem <= len_q;
        end
    end

    a_done_busy: assert property (@(posedge clk_i) disable iff (rst_i) done_q |-> busy_q);
    a_gnt_oh:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
    a_start_gnt: assert property (@(posedge clk_i) disable iff (rst_i) start_q == (gnt_q != '0));
    a_no_ovl:    assert property (@(posedge clk_i) disable iff (rst_i) !(start_q && busy_q));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt_chk
        a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) gnt_q[g] |-> $past(req_i[g]));
    end
`endif

endmodule

// File: tb/tb_busy_sequencer.sv
// Directed vector table plus a randomized run with a round-robin reference model.
module tb_busy_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [4:0] len;
    logic [3:0] gnt;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] owner;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    busy_sequencer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .len_i   (len),
        .gnt_o   (gnt),
        .start_o (start),
        .busy_o  (busy),
        .done_o  (done),
        .owner_o (owner)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [4:0] len;
        logic [3:0] gnt;
        logic       start;
        logic       busy;
        logic       done;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] q, input logic [4:0] l,
                                input logic [3:0] g, input logic s, input logic b,
                                input logic d, input logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = q; v.len = l;
        v.gnt = g; v.start = s; v.busy = b; v.done = d; v.owner = o;
        vecs.push_back(v);
    endfunction

    function automatic int tb_sat(input logic [4:0] l);
        if (l == 0) return 1;
        if (l > 16) return 16;
        return int'(l);
    endfunction

    // Reference model state for the random run
    int         ptr_m;
    int         starts, dones, run_len, exp_len;
    logic [3:0] cur_req;
    logic [4:0] cur_len;

    task automatic sample_cycle();
        int w;
        if (start) begin
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && cur_req[(ptr_m + i) % 4]) w = (ptr_m + i) % 4;
            n_checks++;
            if (w < 0 || gnt != (4'b0001 << w) || int'(owner) != w || busy) begin
                n_fail++;
                $display("FAIL rnd_grant: gnt=%b owner=%0d busy=%b, required winner=%0d of req=%b",
                         gnt, owner, busy, w, cur_req);
            end
            if (w >= 0) ptr_m = (w + 1) % 4;
            starts++;
            exp_len = tb_sat(cur_len);
            run_len = 0;
        end else if (busy) begin
            run_len++;
            if (done) begin
                dones++;
                n_checks++;
                if (run_len != exp_len) begin
                    n_fail++;
                    $display("FAIL rnd_len: busy ran %0d cycles at done, required %0d", run_len, exp_len);
                end
            end
        end
    endtask

    initial begin
        logic [1:0] o;
        logic [3:0] q;

        // reset
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        // single job len 5
        add(0, 4'b0001, 5, 4'b0001, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++) add(0, 4'h0, 0, 4'h0, 0, 1, (k == 5), 0);
        add(0, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        // round robin 0,1,2,3,0 with len 2
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            o = 2'(j % 4);
            q = (j < 4) ? 4'hF : 4'h0;
            add(0, 4'hF, 2, 4'b0001 << o, 1, 0, 0, o);
            add(0, q, 2, 4'h0, 0, 1, 0, o);
            add(0, q, 2, 4'h0, 0, 1, 1, o);
            add(0, q, 2, 4'h0, 0, 0, 0, o);
        end
        // len 0 -> 1 cycle
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 1, 0, 0, 2);
        add(0, 4'h0, 0, 4'h0, 0, 1, 1, 2);
        add(0, 4'h0, 0, 4'h0, 0, 0, 0, 2);
        // len 20 -> saturated to 16
        add(0, 4'b0100, 20, 4'b0100, 1, 0, 0, 2);
        for (int k = 1; k <= 16; k++) add(0, 4'h0, 0, 4'h0, 0, 1, (k == 16), 2);
        add(0, 4'h0, 0, 4'h0, 0, 0, 0, 2);
        // reset on 3rd busy cycle of a len 8 job, pointer returns to 0
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 4'b0001, 8, 4'b0001, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) add(0, 4'h0, 0, 4'h0, 0, 1, 0, 0);
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 4'b0011, 1, 4'b0001, 1, 0, 0, 0);
        add(0, 4'h0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 4'h0, 1, 4'h0, 0, 0, 0, 0);
        add(0, 4'b0010, 1, 4'b0010, 1, 0, 0, 1);
        add(0, 4'h0, 1, 4'h0, 0, 1, 1, 1);
        add(0, 4'h0, 1, 4'h0, 0, 0, 0, 1);
        // requester 2 drops before its turn
        add(1, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 4'b1101, 1, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b1101, 1, 4'h0, 0, 1, 1, 0);
        add(0, 4'b1001, 1, 4'h0, 0, 0, 0, 0);
        add(0, 4'b1001, 1, 4'b1000, 1, 0, 0, 3);
        add(0, 4'b0001, 1, 4'h0, 0, 1, 1, 3);
        add(0, 4'b0001, 1, 4'h0, 0, 0, 0, 3);
        add(0, 4'b0001, 1, 4'b0001, 1, 0, 0, 0);
        add(0, 4'h0, 1, 4'h0, 0, 1, 1, 0);
        add(0, 4'h0, 1, 4'h0, 0, 0, 0, 0);

        rst = 1'b1; req = '0; len = '0;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req = vecs[i].req; len = vecs[i].len;
            @(posedge clk);
            #1;
            n_checks++;
            if (gnt !== vecs[i].gnt || start !== vecs[i].start || busy !== vecs[i].busy ||
                done !== vecs[i].done || owner !== vecs[i].owner) begin
                n_fail++;
                $display("FAIL row%0d: gnt=%b start=%b busy=%b done=%b owner=%0d, required gnt=%b start=%b busy=%b done=%b owner=%0d",
                         i, gnt, start, busy, done, owner, vecs[i].gnt, vecs[i].start,
                         vecs[i].busy, vecs[i].done, vecs[i].owner);
            end
        end

        // random run
        @(negedge clk);
        rst = 1'b1; req = '0; len = '0;
        ptr_m = 0; starts = 0; dones = 0; run_len = 0; exp_len = 0;
        @(negedge clk);
        rst = 1'b0;
        cur_req = 4'($urandom_range(0, 15)); cur_len = 5'($urandom_range(0, 31));
        req = cur_req; len = cur_len;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            sample_cycle();
            cur_req = 4'($urandom_range(0, 15)); cur_len = 5'($urandom_range(0, 31));
            req = cur_req; len = cur_len;
        end
        @(negedge clk);
        sample_cycle();
        cur_req = '0; req = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sample_cycle();
        end
        n_checks++;
        if (starts != dones || starts == 0 || busy) begin
            n_fail++;
            $display("FAIL rnd_balance: starts=%0d dones=%0d busy=%b, required equal nonzero and idle",
                     starts, dones, busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
